uart_receiver: RTL and testbench

//   Serial-to-parallel UART receiver, 8N1, LSB first. Sits directly upstream of the UART

---
 rtl/uart_receiver.sv | 98 +++++++++
 tb/tb_uart_receiver.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, LSB first: 2-flop rx synchroniser, mid-bit sampling,
// one-cycle recv_ok / frame_error pulses per frame.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] recv_data,
  output logic       recv_ok,
  output logic       frame_error,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t        r_state, w_next;
  logic          r_rx_m, r_rx_s;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_sh;
  logic [7:0]    r_recv_data;
  logic          r_recv_ok, r_frame_error;
  logic          w_half, w_last, w_shift, w_ok, w_ferr, w_busy;

  assign w_half = (r_cnt == HALF_M1);
  assign w_last = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_m <= 1'b1;
      r_rx_s <= 1'b1;
    end else begin
      r_rx_m <= rx;
      r_rx_s <= r_rx_m;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!r_rx_s) w_next = S_START;
      S_START: if (w_half) w_next = r_rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (w_last && r_idx == 3'd7) w_next = S_STOP;
      // Leaving STOP at mid-bit lets a start bit with zero idle gap be caught.
      S_STOP:  if (w_last) w_next = r_rx_s ? S_IDLE : S_BREAK;
      S_BREAK: if (r_rx_s) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy  = (r_state != S_IDLE);
    w_shift = (r_state == S_DATA) && w_last;
    w_ok    = (r_state == S_STOP) && w_last && r_rx_s;
    w_ferr  = (r_state == S_STOP) && w_last && !r_rx_s;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt         <= '0;
      r_idx         <= '0;
      r_sh          <= '0;
      r_recv_data   <= '0;
      r_recv_ok     <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_recv_ok     <= w_ok;
      r_frame_error <= w_ferr;
      if (w_ok) r_recv_data <= r_sh;
      if (w_shift) begin
        r_sh  <= {r_rx_s, r_sh[7:1]};
        r_idx <= r_idx + 3'd1;
      end
      case (r_state)
        S_START: begin
          r_cnt <= w_half ? '0 : r_cnt + CW'(1);
          r_idx <= '0;
        end
        S_DATA, S_STOP: r_cnt <= w_last ? '0 : r_cnt + CW'(1);
        default:        r_cnt <= '0;
      endcase
    end
  end

  assign recv_data   = r_recv_data;
  assign recv_ok     = r_recv_ok;
  assign frame_error = r_frame_error;
  assign busy        = w_busy;
endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboarded bench for uart_receiver (CLKS_PER_BIT=8): directed scenarios plus
// random frames, glitches and framing errors against a frame-level model.
module tb_uart_receiver;
  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] recv_data;
  logic       recv_ok, frame_error, busy;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .rx(rx), .recv_data(recv_data),
    .recv_ok(recv_ok), .frame_error(frame_error), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { bit err; logic [7:0] data; } exp_t;
  exp_t q[$];
  int   ok_cycs[$];
  int   cyc = 0, checks = 0, errors = 0, ok_cnt = 0, ferr_cnt = 0;
  logic [7:0] model_last = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: a good stop bit delivers the byte; a bad one reports an error and
  // leaves the last good byte visible.
  task automatic send_frame(input logic [7:0] d, input bit stop);
    exp_t e;
    e.err  = !stop;
    e.data = stop ? d : model_last;
    if (stop) model_last = d;
    q.push_back(e);
    rx = 1'b0; tick(CPB);
    for (int i = 0; i < 8; i++) begin rx = d[i]; tick(CPB); end
    rx = stop; tick(CPB);
  endtask

  // Monitor: pops one expectation per pulse cycle.
  always @(negedge clk) begin
    if (!reset && (recv_ok || frame_error)) begin
      exp_t e;
      if (recv_ok && frame_error) chk("ok_and_ferr_together", 1, 0);
      if (q.size() == 0) begin
        chk("unexpected_pulse", {recv_ok, frame_error}, 0);
      end else begin
        e = q.pop_front();
        chk("pulse_kind_is_err", frame_error, e.err);
        chk("recv_data", recv_data, e.data);
      end
      if (recv_ok) begin ok_cnt++; ok_cycs.push_back(cyc); end
      if (frame_error) ferr_cnt++;
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted at %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, n0, f0, r, len;
    logic [7:0] d;
    // Reset
    rx = 1'b1; reset = 1'b1; tick(5); reset = 1'b0; tick(20);
    chk("rst_recv_ok", recv_ok, 0);
    chk("rst_frame_error", frame_error, 0);
    chk("rst_busy", busy, 0);
    chk("rst_recv_data", recv_data, 0);

    // Single frame: 2 sync cycles + H + 9 bits + 1 registered cycle
    n0 = ok_cnt; c = cyc;
    send_frame(8'hB3, 1'b1);
    tick(4);
    chk("b3_pulse_count", ok_cnt - n0, 1);
    chk("b3_latency", ok_cycs[$] - c, 2 + CPB/2 + 9*CPB + 1);
    chk("b3_busy_after", busy, 0);

    // Back-to-back, zero idle gap
    n0 = ok_cnt; f0 = ferr_cnt;
    send_frame(8'h5F, 1'b1);
    send_frame(8'hAA, 1'b1);
    tick(4);
    chk("b2b_pulse_count", ok_cnt - n0, 2);
    chk("b2b_spacing", ok_cycs[$] - ok_cycs[$-1], 10*CPB);
    chk("b2b_no_ferr", ferr_cnt - f0, 0);

    // Glitch shorter than half a bit
    n0 = ok_cnt; f0 = ferr_cnt;
    rx = 1'b0; tick(2); rx = 1'b1; tick(8);
    chk("glitch_busy", busy, 0);
    chk("glitch_no_pulse", (ok_cnt - n0) + (ferr_cnt - f0), 0);
    tick(4);
    send_frame(8'h01, 1'b1);
    tick(4);

    // Framing error, line held low
    n0 = ok_cnt; f0 = ferr_cnt;
    send_frame(8'h0F, 1'b0);
    tick(30);
    chk("ferr_busy_held", busy, 1);
    rx = 1'b1; tick(4);
    chk("ferr_busy_released", busy, 0);
    chk("ferr_count", ferr_cnt - f0, 1);
    chk("ferr_no_ok", ok_cnt - n0, 0);
    tick(4);
    send_frame(8'h3C, 1'b1);
    tick(4);

    // Reset during data bit 4 of 0xFF
    n0 = ok_cnt;
    rx = 1'b0; tick(CPB);
    for (int i = 0; i < 4; i++) begin rx = 1'b1; tick(CPB); end
    tick(4);
    reset = 1'b1; tick(1); reset = 1'b0;
    model_last = 8'h00;
    chk("midrst_recv_data", recv_data, 0);
    chk("midrst_busy", busy, 0);
    tick(10);
    chk("midrst_no_pulse", ok_cnt - n0, 0);
    send_frame(8'hA5, 1'b1);
    tick(4);
    chk("a5_pulse_count", ok_cnt - n0, 1);

    // Random traffic
    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        len = $urandom_range(1, 3);
        rx = 1'b0; tick(len); rx = 1'b1; tick(8);
      end else begin
        d = 8'($urandom);
        send_frame(d, r != 1);
        if (r == 1) begin
          tick($urandom_range(0, 20));
          rx = 1'b1; tick(4);
        end
      end
      tick($urandom_range(0, 12));
    end
    tick(20);
    chk("scoreboard_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
